// File: rtl/stream_aligner_pkg.sv
// Shared widths, buffer geometry and the FIFO record layout for the stream aligner.
package stream_aligner_pkg;

  localparam int TAG_WIDTH       = 16;
  localparam int DATA_OUT_WIDTH  = 256;
  localparam int DATA_IN_WIDTH   = TAG_WIDTH + DATA_OUT_WIDTH;
  localparam int LEN_WIDTH       = 8;
  localparam int FIFO_ADDR_WIDTH = 8;
  localparam int AF_MARGIN       = 4;

  localparam int OUT_BYTES = DATA_OUT_WIDTH / 8;
  localparam int REC_BYTES = DATA_IN_WIDTH / 8;
  // Worst case: 31 residual bytes plus a full 34-byte record.
  localparam int BUF_BYTES = 66;
  localparam int BUF_WIDTH = BUF_BYTES * 8;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]      tag;
    logic [DATA_OUT_WIDTH-1:0] data;
    logic [LEN_WIDTH-1:0]      len;
  } record_t;

endpackage

// File: rtl/stream_aligner_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is a registered read of the RAM,
// fetched from the next read address so it is valid the cycle after a push.
module sync_fifo #(
  parameter int DATA_WIDTH = 280,
  parameter int ADDR_WIDTH = 8,
  parameter int AF_MARGIN  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_COUNT   = (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_head;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;

  logic                  w_do_wr;
  logic                  w_do_rd;
  logic [ADDR_WIDTH-1:0] w_rd_ptr_next;

  assign empty         = (r_count == '0);
  assign full          = (r_count == FULL_COUNT);
  assign almost_full   = (r_count >= AF_COUNT);
  assign count         = r_count;
  assign rd_data       = r_head;
  assign w_do_wr       = wr_en && !full;
  assign w_do_rd       = rd_en && !empty;
  assign w_rd_ptr_next = r_rd_ptr + ADDR_WIDTH'(w_do_rd);

  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Bypass covers a write landing on the slot that becomes the head this edge.
  always_ff @(posedge clk) begin
    if (w_do_wr && (r_wr_ptr == w_rd_ptr_next)) begin
      r_head <= wr_data;
    end else begin
      r_head <= r_mem[w_rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      r_rd_ptr <= w_rd_ptr_next;
      if (w_do_wr && !w_do_rd) begin
        r_count <= r_count + (ADDR_WIDTH+1)'(1);
      end else if (!w_do_wr && w_do_rd) begin
        r_count <= r_count - (ADDR_WIDTH+1)'(1);
      end
    end
  end

endmodule

// File: rtl/stream_aligner.sv
// Packs variable-length {tag, data} records byte-granular into dense 256-bit words,
// MSB-first, emitting at most one word per cycle.
module stream_aligner
  import stream_aligner_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [TAG_WIDTH-1:0]       tag_in,
  input  logic [DATA_OUT_WIDTH-1:0]  data_in,
  input  logic [LEN_WIDTH-1:0]       len_in,
  output logic                       full,
  output logic                       almost_full,
  output logic [FIFO_ADDR_WIDTH:0]   fifo_count,
  output logic [DATA_OUT_WIDTH-1:0]  data_out,
  output logic                       valid,
  output logic                       stall,
  output logic [8:0]                 new_len
);

  record_t                   w_wr_rec;
  record_t                   w_head;
  logic                      w_empty;
  logic                      w_wrt_en;
  logic [5:0]                w_len_clamp;
  logic [5:0]                w_rec_bytes;
  logic [DATA_IN_WIDTH-1:0]  w_rec;
  logic [DATA_IN_WIDTH-1:0]  w_rec_masked;
  logic [BUF_WIDTH-1:0]      w_buf_ins;
  logic [BUF_WIDTH-1:0]      w_buf;
  logic [7:0]                w_total;
  logic [7:0]                w_occ_next;
  logic                      w_emit;

  logic [BUF_WIDTH-1:0]      r_buf;
  logic [7:0]                r_occ;
  logic [DATA_OUT_WIDTH-1:0] r_data_out;
  logic                      r_valid;
  logic                      r_stall;

  assign w_wr_rec = '{tag: tag_in, data: data_in, len: len_in};

  sync_fifo #(
    .DATA_WIDTH ($bits(record_t)),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH),
    .AF_MARGIN  (AF_MARGIN)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (push),
    .wr_data     (w_wr_rec),
    .rd_en       (w_wrt_en),
    .rd_data     (w_head),
    .empty       (w_empty),
    .full        (full),
    .almost_full (almost_full),
    .count       (fifo_count)
  );

  assign w_wrt_en    = !w_empty && !r_stall;
  assign w_len_clamp = (w_head.len > LEN_WIDTH'(OUT_BYTES)) ? 6'(OUT_BYTES) : w_head.len[5:0];
  assign w_rec_bytes = w_len_clamp + 6'd2;
  assign w_rec       = {w_head.tag, w_head.data};

  // Zero every byte past the record's length so the OR-insert below keeps the
  // buffer's "bytes beyond occupancy are zero" invariant.
  for (genvar gi = 0; gi < REC_BYTES; gi++) begin : g_mask
    assign w_rec_masked[DATA_IN_WIDTH-1-8*gi -: 8] =
      (6'(gi) < w_rec_bytes) ? w_rec[DATA_IN_WIDTH-1-8*gi -: 8] : 8'h00;
  end

  assign w_buf_ins  = {w_rec_masked, {(BUF_WIDTH-DATA_IN_WIDTH){1'b0}}} >> {r_occ, 3'b000};
  assign w_buf      = w_wrt_en ? (r_buf | w_buf_ins) : r_buf;
  assign w_total    = r_occ + (w_wrt_en ? {2'b00, w_rec_bytes} : 8'd0);
  assign w_emit     = (w_total >= 8'(OUT_BYTES));
  assign w_occ_next = w_emit ? (w_total - 8'(OUT_BYTES)) : w_total;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf      <= '0;
      r_occ      <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_stall    <= 1'b0;
    end else begin
      r_valid <= w_emit;
      r_occ   <= w_occ_next;
      r_stall <= (w_occ_next >= 8'(OUT_BYTES));
      if (w_emit) begin
        r_data_out <= w_buf[BUF_WIDTH-1 -: DATA_OUT_WIDTH];
        r_buf      <= w_buf << DATA_OUT_WIDTH;
      end else begin
        r_buf <= w_buf;
      end
    end
  end

  assign data_out = r_data_out;
  assign valid    = r_valid;
  assign stall    = r_stall;
  assign new_len  = {1'b0, r_occ};

endmodule

// File: tb/tb_stream_aligner.sv
// Self-checking bench for stream_aligner: directed vector table, randomized traffic
// against a queue-based byte model, and FIFO fill / mid-stream reset sequences.
module tb_stream_aligner;

  logic         clk = 1'b0;
  logic         reset;
  logic         push;
  logic [15:0]  tag_in;
  logic [255:0] data_in;
  logic [7:0]   len_in;
  logic         full;
  logic         almost_full;
  logic [8:0]   fifo_count;
  logic [255:0] data_out;
  logic         valid;
  logic         stall;
  logic [8:0]   new_len;

  always #5 clk = ~clk;

  stream_aligner dut (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .tag_in      (tag_in),
    .data_in     (data_in),
    .len_in      (len_in),
    .full        (full),
    .almost_full (almost_full),
    .fifo_count  (fifo_count),
    .data_out    (data_out),
    .valid       (valid),
    .stall       (stall),
    .new_len     (new_len)
  );

  typedef struct {
    logic [15:0]  tag;
    logic [255:0] data;
    logic [7:0]   len;
  } rec_t;

  typedef struct {
    logic         p;
    logic [15:0]  tag;
    logic [255:0] data;
    logic [7:0]   len;
    logic         exp_valid;
    logic [255:0] exp_data;
    logic [8:0]   exp_len;
    logic [8:0]   exp_cnt;
  } vec_t;

  // Reference model: records waiting in the FIFO and the byte stream not yet emitted.
  rec_t         m_fifo[$];
  logic [7:0]   m_buf[$];
  logic         m_stall;
  logic         m_valid;
  logic [255:0] m_word;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [271:0] act, input logic [271:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_buf.delete();
    m_stall = 1'b0;
    m_valid = 1'b0;
    m_word  = '0;
  endtask

  task automatic model_edge(input logic p, input logic [15:0] t, input logic [255:0] d,
                            input logic [7:0] l);
    rec_t r;
    int   pre_size;
    int   n;
    pre_size = m_fifo.size();
    if (pre_size > 0 && !m_stall) begin
      r = m_fifo.pop_front();
      n = (int'(r.len) > 32) ? 32 : int'(r.len);
      m_buf.push_back(r.tag[15:8]);
      m_buf.push_back(r.tag[7:0]);
      for (int i = 0; i < n; i++) m_buf.push_back(r.data[255-8*i -: 8]);
    end
    if (p && pre_size < 256) begin
      r.tag = t; r.data = d; r.len = l;
      m_fifo.push_back(r);
    end
    m_valid = 1'b0;
    if (m_buf.size() >= 32) begin
      for (int i = 0; i < 32; i++) m_word[255-8*i -: 8] = m_buf.pop_front();
      m_valid = 1'b1;
    end
    m_stall = (m_buf.size() >= 32);
  endtask

  task automatic compare_all(input string nm);
    chk({nm, ".valid"},       272'(valid),       272'(m_valid));
    chk({nm, ".data_out"},    272'(data_out),    272'(m_word));
    chk({nm, ".new_len"},     272'(new_len),     272'(m_buf.size()));
    chk({nm, ".stall"},       272'(stall),       272'(m_stall));
    chk({nm, ".fifo_count"},  272'(fifo_count),  272'(m_fifo.size()));
    chk({nm, ".full"},        272'(full),        272'(m_fifo.size() == 256));
    chk({nm, ".almost_full"}, 272'(almost_full), 272'(m_fifo.size() >= 252));
  endtask

  task automatic step(input logic p, input logic [15:0] t, input logic [255:0] d,
                      input logic [7:0] l, input string nm);
    push = p; tag_in = t; data_in = d; len_in = l;
    @(posedge clk);
    model_edge(p, t, d, l);
    #1;
    compare_all(nm);
    push = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    push  = 1'b0;
    repeat (cycles) @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  localparam logic [255:0] W1 =
    256'h46DB_1234_5678_9ABC_DEF1_2345_6789_ABCD_EFA9_6412_3456_789A_BCDE_F123_4567_0625;
  localparam logic [255:0] W2 =
    {56'h3456789ABCDEF1, 16'h800B, 64'h0102030405060708, 16'h0000, 16'hFFFF,
     88'hA0A1A2A3A4A5A6A7A8A9AA};

  vec_t vecs[7];

  initial begin
    int words;
    int cyc;
    logic saw_stall;

    reset = 1'b1; push = 1'b0; tag_in = '0; data_in = '0; len_in = '0;
    model_reset();

    // Reset state
    do_reset(2);
    chk("reset.valid",       272'(valid),       272'(1'b0));
    chk("reset.data_out",    272'(data_out),    272'(256'h0));
    chk("reset.stall",       272'(stall),       272'(1'b0));
    chk("reset.full",        272'(full),        272'(1'b0));
    chk("reset.almost_full", 272'(almost_full), 272'(1'b0));
    chk("reset.fifo_count",  272'(fifo_count),  272'(9'd0));
    chk("reset.new_len",     272'(new_len),     272'(9'd0));

    // Directed packing table
    vecs[0] = '{1'b1, 16'h46DB, {120'h123456789ABCDEF123456789ABCDEF, {17{8'hEE}}}, 8'h0F,
                1'b0, 256'h0, 9'd0, 9'd1};
    vecs[1] = '{1'b1, 16'hA964, {88'h123456789ABCDEF1234567, {21{8'h5A}}}, 8'h0B,
                1'b0, 256'h0, 9'd17, 9'd1};
    vecs[2] = '{1'b1, 16'h0625, {56'h3456789ABCDEF1, {25{8'hC3}}}, 8'h07,
                1'b0, 256'h0, 9'd30, 9'd1};
    vecs[3] = '{1'b1, 16'h800B, {64'h0102030405060708, {24{8'h77}}}, 8'h08,
                1'b1, W1, 9'd7, 9'd1};
    vecs[4] = '{1'b1, 16'h0000, {32{8'h99}}, 8'h00,
                1'b0, W1, 9'd17, 9'd1};
    vecs[5] = '{1'b1, 16'hFFFF,
                256'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAFB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF, 8'h20,
                1'b0, W1, 9'd19, 9'd1};
    vecs[6] = '{1'b0, 16'h0000, 256'h0, 8'h00,
                1'b1, W2, 9'd21, 9'd0};
    for (int i = 0; i < 7; i++) begin
      step(vecs[i].p, vecs[i].tag, vecs[i].data, vecs[i].len, "vec");
      $display("vec %0d push=%0b tag=%h len=%0d -> valid=%0b new_len=%0d count=%0d",
               i, vecs[i].p, vecs[i].tag, vecs[i].len, valid, new_len, fifo_count);
      chk("vec.valid",      272'(valid),      272'(vecs[i].exp_valid));
      chk("vec.data_out",   272'(data_out),   272'(vecs[i].exp_data));
      chk("vec.new_len",    272'(new_len),    272'(vecs[i].exp_len));
      chk("vec.fifo_count", 272'(fifo_count), 272'(vecs[i].exp_cnt));
    end

    // Randomized traffic, lengths include the clamped >32 range
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 9) < 6), 16'($urandom), rand256(),
           8'($urandom_range(0, 40)), "rand");
    end
    $display("random phase done: compared=%0d", n_cmp);

    // Back-to-back full-size records
    do_reset(1);
    words = 0;
    saw_stall = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(i < 40, 16'(i), rand256(), 8'd32, "b2b");
      if (valid) words++;
      if (stall) saw_stall = 1'b1;
    end
    $display("b2b: words=%0d residual=%0d", words, new_len);
    chk("b2b.words",      272'(words),     272'(42));
    chk("b2b.residual",   272'(new_len),   272'(9'd16));
    chk("b2b.stall_seen", 272'(saw_stall), 272'(1'b1));

    // Fill the FIFO: continuous 32-byte pushes outpace the drain by one per 17 cycles
    do_reset(1);
    cyc = 0;
    while (m_fifo.size() < 256 && cyc < 8000) begin
      step(1'b1, 16'(cyc), rand256(), 8'd32, "fill");
      cyc++;
    end
    $display("fill: cycles=%0d count=%0d full=%0b", cyc, fifo_count, full);
    chk("fill.full",        272'(full),        272'(1'b1));
    chk("fill.almost_full", 272'(almost_full), 272'(1'b1));
    chk("fill.count",       272'(fifo_count),  272'(9'd256));
    step(1'b1, 16'hDEAD, rand256(), 8'd32, "push_at_full");
    $display("push at full: count=%0d", fifo_count);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 256'h0, 8'd0, "post_full");

    // Mid-stream reset discards FIFO contents and buffered bytes
    do_reset(1);
    compare_all("midreset");
    chk("midreset.fifo_count", 272'(fifo_count), 272'(9'd0));
    chk("midreset.new_len",    272'(new_len),    272'(9'd0));
    chk("midreset.valid",      272'(valid),      272'(1'b0));
    step(1'b0, 16'h0, 256'h0, 8'd0, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_aligner.md
Name: stream_aligner

Overview:
- Packs variable-length compressed records into dense 256-bit output words; sits between the compressor back end and the output writer.
- Each record is a 16-bit tag plus len bytes of MSB-aligned compressed data, i.e. 2+len bytes.
- Records are buffered in an internal synchronous FIFO, then concatenated byte-granular with no gaps and emitted 32 bytes at a time.

Parameters:
- TAG_WIDTH, 16, tag bits per record.
- DATA_OUT_WIDTH, 256, payload and output word bits.
- DATA_IN_WIDTH, 272, TAG_WIDTH+DATA_OUT_WIDTH; aligner record input.
- LEN_WIDTH, 8, byte-count field width.
- FIFO_ADDR_WIDTH, 8, FIFO depth = 2**FIFO_ADDR_WIDTH = 256 entries of 280 bits.
- AF_MARGIN, 4, almost_full asserts when count >= depth-AF_MARGIN.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- push  in  1  write one record into the FIFO.
- tag_in  in  16  record tag.
- data_in  in  256  compressed bytes, MSB-first, left-aligned.
- len_in  in  8  valid byte count of data_in (0..32).
- full  out  1  FIFO full.
- almost_full  out  1  FIFO count >= depth-AF_MARGIN.
- fifo_count  out  9  FIFO occupancy.
- data_out  out  256  packed output word, oldest byte in [255:248].
- valid  out  1  data_out holds a new word this cycle.
- stall  out  1  aligner refusing input this cycle.
- new_len  out  9  bytes held in the aligner buffer after the last edge.

Behaviour:
- Reset: FIFO empty, count 0, pointers 0; aligner buffer 0, occupancy 0; data_out=0, valid=0, stall=0, full=0, almost_full=0.
- FIFO:
  - Show-ahead (first-word-fall-through). Stored entry = {tag, data, len}, 280 bits.
  - Push while full is ignored, even if a pop occurs in the same cycle.
  - Pop while empty is ignored.
  - Simultaneous push and pop with 0<count<depth: count unchanged.
  - Pointers wrap modulo depth.
  - full is asserted when count==depth.
- Aligner accept:
  - Internal wrt_en = !empty && !stall; a FIFO pop occurs exactly when wrt_en is high.
  - len > 32 is clamped to 32.
  - Record bytes = {tag, top len bytes of data}, 2+len bytes.
  - The record is appended directly after the current occupancy in a 66-byte MSB-first buffer.
- Aligner emit, registered with the same edge as the accept:
  - Let t = occupancy + accepted bytes.
  - If t >= 32: data_out <= first 32 buffer bytes; valid <= 1; buffer shifts left 32 bytes; occupancy <= t-32.
  - Otherwise: valid <= 0; occupancy <= t; data_out holds its previous value.
  - Only one word is emitted per cycle.
- stall:
  - Registered; stall <= (new occupancy >= 32).
  - While stall is high no record is accepted, but emission still proceeds. Maximum occupancy is 65 bytes.
- Latency: a record pushed at edge N is visible at the FIFO head after N and can be accepted at edge N+1. A word completed by that record has valid=1 after edge N+1.
- Zero-length record: contributes only its 2 tag bytes.
- Reset asserted mid-stream discards all buffered bytes and FIFO contents.
- No flush of a partial word; residual bytes remain until filled.

Decomposition:
- Shared package: TAG_WIDTH, DATA_OUT_WIDTH, LEN_WIDTH, and a record struct {tag, data, len}.
- Sub-module: sync_fifo (parameterized DATA_WIDTH/ADDR_WIDTH, show-ahead, full/almost_full/count).
- Top level holds the aligner buffer, the byte shifter and the occupancy counter.

Test Plan:
- Reset for 2 cycles -> all outputs 0, fifo_count=0, new_len=0.
- Push three records: (46DB, 123456789ABCDEF123456789ABCDEF00.., len 0F), (A964, 123456789ABCDEF1234567.., len 0B), (0625, 3456789ABCDEF1.., len 07) -> one valid pulse with data_out=46DB_1234_5678_9ABC_DEF1_2345_6789_ABCD_EFA9_6412_3456_789A_BCDE_F123_4567_0625; new_len=7.
- Continue with (800B, len 08), (0000, len 00), (FFFF, full 32-byte data, len 20) -> new_len 17, then 19; then valid with residual 21.
- Back-to-back 32-byte records with the FIFO pre-filled -> stall toggles; no byte lost or duplicated; one valid word per cycle while occupancy >= 32.
- Push 256 records with no drain (force stall) -> full=1 at count 256, almost_full from count 252; the 257th push is ignored.
- Assert reset with occupancy 20 and FIFO count 5 -> next cycle all counts 0; valid=0.
